// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, grant-select encoding and the arbitration rule for the
// unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W   = 32;
  localparam int MEM_DATA_W   = 32;
  localparam int STARVE_CNT_W = 4;

  // Which requester owns the memory port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_DM   = 2'b10
  } gnt_sel_e;

  // DM has fixed priority unless IF has been denied long enough to hit the
  // starvation limit, in which case IF wins the conflict.
  function automatic gnt_sel_e arbitrate(input logic if_req,
                                         input logic dm_req,
                                         input logic if_starved);
    gnt_sel_e sel;
    sel = GNT_NONE;
    if (if_req && dm_req) begin
      sel = if_starved ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      sel = GNT_DM;
    end else if (if_req) begin
      sel = GNT_IF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive denied IF cycles. Counts up on inc,
// clears on clr (clr wins), stops at max and never wraps.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  input  logic [STARVE_CNT_W-1:0] max,
  output logic                    at_max
);

  logic [STARVE_CNT_W-1:0] cnt;

  // Count denied cycles, saturating at max.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < max)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == max);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory (combinational read, clocked write) between
// the instruction-fetch (read-only) and data (read/write) requesters. At most
// one access is granted per cycle; read data returns one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C = STARVE_CNT_W'(STARVE_MAX);

  gnt_sel_e gnt_sel;
  logic     if_starved;
  logic     dm_rd;

  // Starvation tracking: count cycles IF asks but loses; any IF grant or an
  // idle IF cycle restarts the count.
  arb_starve_counter u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (if_req & ~if_gnt),
    .clr    (if_gnt | ~if_req),
    .max    (STARVE_MAX_C),
    .at_max (if_starved)
  );

  // Same-cycle grant decision; held at no-grant while reset is asserted.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // leaves it unassigned and infers a latch.
    gnt_sel = GNT_NONE;
    if (rst_n) begin
      gnt_sel = arbitrate(if_req, dm_req, if_starved);
    end
  end

  assign if_gnt = (gnt_sel == GNT_IF);
  assign dm_gnt = (gnt_sel == GNT_DM);
  assign dm_rd  = dm_gnt & ~dm_we;

  // Steer the memory port to the granted requester; idle port reads word 0.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (gnt_sel)
      GNT_IF: begin
        mem_addr = if_addr;
      end
      GNT_DM: begin
        mem_addr  = dm_addr;
        mem_we    = dm_we;
        mem_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  // IF read response: one-cycle valid pulse; data holds until the next IF read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) begin
        if_rdata <= mem_rdata;
      end
    end
  end

  // DM read response: reads only; writes produce no valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      dm_rvalid <= dm_rd;
      if (dm_rd) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 16-word memory attached to the memory port,
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory instance: combinational read, write on posedge.
  logic [DATA_W-1:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [DATA_W-1:0] ref_mem [16];
  int                denied;
  logic              e_ifv, e_dmv;
  logic [DATA_W-1:0] e_ifd, e_dmd;

  always @(negedge clk) begin : cmp
    logic              e_if_g, e_dm_g;
    logic [ADDR_W-1:0] e_addr;
    if (!rst_n) begin
      denied = 0;
      e_ifv  = 1'b0;
      e_dmv  = 1'b0;
      e_ifd  = '0;
      e_dmd  = '0;
      check("rst if_gnt",    if_gnt,    0);
      check("rst dm_gnt",    dm_gnt,    0);
      check("rst mem_we",    mem_we,    0);
      check("rst if_rvalid", if_rvalid, 0);
      check("rst dm_rvalid", dm_rvalid, 0);
      check("rst if_rdata",  if_rdata,  0);
      check("rst dm_rdata",  dm_rdata,  0);
    end else begin
      // DM wins unless IF has already been refused STARVE_MAX times in a row.
      e_dm_g = dm_req && !(if_req && denied == STARVE_MAX);
      e_if_g = if_req && !e_dm_g;
      e_addr = e_dm_g ? dm_addr : (e_if_g ? if_addr : '0);
      check("if_gnt",    if_gnt,    e_if_g);
      check("dm_gnt",    dm_gnt,    e_dm_g);
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_we",    mem_we,    e_dm_g && dm_we);
      if (e_dm_g && dm_we) check("mem_wdata", mem_wdata, dm_wdata);
      check("if_rvalid", if_rvalid, e_ifv);
      check("dm_rvalid", dm_rvalid, e_dmv);
      check("if_rdata",  if_rdata,  e_ifd);
      check("dm_rdata",  dm_rdata,  e_dmd);
      // Effects of the coming rising edge.
      e_ifv = e_if_g;
      if (e_if_g) e_ifd = ref_mem[if_addr[3:0]];
      e_dmv = e_dm_g && !dm_we;
      if (e_dmv) e_dmd = ref_mem[dm_addr[3:0]];
      if (e_dm_g && dm_we) ref_mem[dm_addr[3:0]] = dm_wdata;
      if (if_req && !e_if_g) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
      else denied = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    mem[0] = 32'h1000_0001; ref_mem[0] = 32'h1000_0001;
    mem[1] = 32'h1000_000F; ref_mem[1] = 32'h1000_000F;
    mem[2] = 32'h0;         ref_mem[2] = 32'h0;

    // 1. reset, then a single IF read of word 0
    repeat (3) step();
    check("t1 rst if_rvalid", if_rvalid, 0);
    check("t1 rst if_rdata",  if_rdata,  0);
    rst_n = 1'b1;
    step();
    if_req = 1'b1; if_addr = 0;
    #1 check("t1 if_gnt", if_gnt, 1);
    step();
    if_req = 1'b0;
    check("t1 if_rvalid", if_rvalid, 1);
    check("t1 if_rdata",  if_rdata,  32'h1000_0001);
    check("t1 dm_rvalid", dm_rvalid, 0);

    // 2. DM write then read-back of word 2
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 2; dm_wdata = 32'hDEAD_BEEF;
    #1 check("t2 wr mem_we", mem_we, 1);
    step();
    dm_we = 1'b0;
    check("t2 no rvalid on write", dm_rvalid, 0);
    step();
    dm_req = 1'b0;
    check("t2 dm_rvalid", dm_rvalid, 1);
    check("t2 dm_rdata",  dm_rdata,  32'hDEAD_BEEF);
    check("t2 if_rvalid", if_rvalid, 0);

    // 3. both held: DM x4, IF on 5th, DM again on 6th
    if_req = 1'b1; if_addr = 0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      #1;
      check("t3 dm_gnt", dm_gnt, (c == 4) ? 1'b0 : 1'b1);
      check("t3 if_gnt", if_gnt, (c == 4) ? 1'b1 : 1'b0);
    end
    step();
    if_req = 1'b0; dm_req = 1'b0;

    // 4. conflict with fresh counter
    step();
    if_req = 1'b1; if_addr = 7; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 3; dm_wdata = 32'h5;
    #1;
    check("t4 dm_gnt",   dm_gnt,   1);
    check("t4 if_gnt",   if_gnt,   0);
    check("t4 mem_addr", mem_addr, 3);
    check("t4 mem_we",   mem_we,   1);
    step();
    dm_we = 1'b0;
    #1 check("t4 rd mem_we", mem_we, 0);
    step();
    if_req = 1'b0; dm_req = 1'b0;

    // 5. async reset right after an IF read grant
    step();
    if_req = 1'b1; if_addr = 1;
    #1 check("t5 if_gnt", if_gnt, 1);
    step();
    if_req = 1'b0;
    check("t5 if_rvalid pre", if_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t5 if_rvalid async", if_rvalid, 0);
    check("t5 if_rdata async",  if_rdata,  0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t5 if_rvalid after", if_rvalid, 0);
    step();
    check("t5 if_rvalid after2", if_rvalid, 0);

    // 6. idle with held read data
    if_req = 1'b1; if_addr = 0;
    step();
    if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 1;
    step();
    dm_req = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6 mem_we",    mem_we,    0);
      check("t6 if_rvalid", if_rvalid, 0);
      check("t6 dm_rvalid", dm_rvalid, 0);
      check("t6 if_rdata",  if_rdata,  32'h1000_0001);
      check("t6 dm_rdata",  dm_rdata,  32'h1000_000F);
    end

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n    = ($urandom_range(0, 199) != 0);
      if_req   = ($urandom_range(0, 99) < 60);
      dm_req   = ($urandom_range(0, 99) < 75);
      dm_we    = ($urandom_range(0, 1) == 1);
      if_addr  = 32'($urandom_range(0, 15));
      dm_addr  = 32'($urandom_range(0, 15));
      dm_wdata = $urandom;
    end
    step();
    rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
